branch_resolve: RTL

ID-stage branch resolution unit placed directly downstream of `branch_pre`. It evaluates each conditional branch once its operands are read, compares the actual outcome with the prediction that travelled down the pipeline, and returns a one-cycle training update to `branch_pre`. On a mispredict it issues a redirect to `pc_reg` and a flush to `ctrl`. It also keeps saturating branch and mispredict counters for performance inspection.

---
 rtl/branch_resolve_pkg.sv | 12 +
 rtl/branch_cmp.sv | 20 ++
 rtl/branch_resolve.sv | 95 +++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: opcode, funct3 codes and FSM encodings for branch resolution.
package branch_resolve_pkg;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [2:0]  F3_BEQ    = 3'b000;
  localparam logic [2:0]  F3_BNE    = 3'b001;
  localparam logic [2:0]  F3_BLT    = 3'b100;
  localparam logic [2:0]  F3_BGE    = 3'b101;
  localparam logic [2:0]  F3_BLTU   = 3'b110;
  localparam logic [2:0]  F3_BGEU   = 3'b111;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: evaluates a conditional branch condition from funct3 and operands.
module branch_cmp
  import branch_resolve_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken,
  output logic        is_legal
);
  logic eq, lt, ltu;
  always_comb begin
    eq       = rs1 == rs2;
    lt       = $signed(rs1) < $signed(rs2);
    ltu      = rs1 < rs2;
    is_legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT) ||
               (funct3 == F3_BGE) || (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
    taken    = (funct3[2] ? (funct3[1] ? ltu : lt) : eq) ^ funct3[0];
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves ID-stage branches, trains the predictor, and issues redirect/flush on mispredict.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_pc_i,
  input  logic [31:0]      id_inst_i,
  input  logic [31:0]      reg1_data_i,
  input  logic [31:0]      reg2_data_i,
  input  logic             id_pre_take_i,
  input  logic             id_pre_sel_i,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic             upd_pre_true_o,
  output logic             upd_sel_o,
  output logic [31:0]      upd_pc_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_addr_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);
  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic        taken, is_legal, resolve, mispredict;
  logic [31:0] imm, target, fallthrough;
  logic        unused;
  assign unused = ^id_inst_i[24:15];
  branch_cmp u_cmp (
    .funct3  (id_inst_i[14:12]),
    .rs1     (reg1_data_i),
    .rs2     (reg2_data_i),
    .taken   (taken),
    .is_legal(is_legal)
  );
  always_comb begin
    imm         = {{20{id_inst_i[31]}}, id_inst_i[7], id_inst_i[30:25], id_inst_i[11:8], 1'b0};
    target      = id_pc_i + imm;
    fallthrough = id_pc_i + 32'd4;
    resolve     = id_valid_i && (id_inst_i[6:0] == OP_BRANCH) && is_legal && !stall_i && (state == S_IDLE);
    mispredict  = taken ^ id_pre_take_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == S_IDLE && resolve && mispredict) begin
      state_d = S_FLUSH;
      cnt_d   = 3'(FLUSH_CYCLES - 1);
    end else if (state == S_FLUSH) begin
      state_d = (cnt == 3'd0) ? S_IDLE : S_FLUSH;
      cnt_d   = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
    end
  end
  always_comb flush_o = state == S_FLUSH;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid_o     <= 1'b0;
      upd_taken_o     <= 1'b0;
      upd_pre_true_o  <= 1'b0;
      upd_sel_o       <= 1'b0;
      upd_pc_o        <= ZERO_WORD;
      redirect_o      <= 1'b0;
      redirect_addr_o <= ZERO_WORD;
      branch_cnt_o    <= '0;
      mispred_cnt_o   <= '0;
    end else begin
      upd_valid_o <= resolve;
      redirect_o  <= resolve && mispredict;
      if (resolve) begin
        upd_taken_o    <= taken;
        upd_pre_true_o <= !mispredict;
        upd_sel_o      <= id_pre_sel_i;
        upd_pc_o       <= id_pc_i;
      end
      if (resolve && mispredict) redirect_addr_o <= taken ? target : fallthrough;
      if (resolve && !(&branch_cnt_o)) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (resolve && mispredict && !(&mispred_cnt_o)) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end
  end
endmodule
